uart_seq: RTL and testbench



---
 rtl/uart_seq_pkg.sv | 32 +++
 rtl/uart_seq_rr_arbiter.sv | 32 +++
 rtl/uart_seq.sv | 180 ++++++++++++++++++
 tb/tb_uart_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART bus sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    INIT_CPB,
    INIT_CTRL,
    IDLE,
    RX_POLL,
    RX_READ,
    TX_POLL,
    TX_WRITE,
    GAP
  } state_t;

  // UART register map
  localparam logic [3:0] ADDR_DR    = 4'd0;
  localparam logic [3:0] ADDR_CTRL  = 4'd1;
  localparam logic [3:0] ADDR_RSTAT = 4'd2;
  localparam logic [3:0] ADDR_TSTAT = 4'd3;
  localparam logic [3:0] ADDR_CPB   = 4'd4;

  // Status bit positions and control value (RX_EN | TX_EN)
  localparam int unsigned RXNE_BIT = 0;
  localparam int unsigned TC_BIT   = 0;
  localparam int unsigned CTRL_VAL = 3;

  // Index width for n requesters, never below one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_seq_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, with wrap.
module uart_seq_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   grant,
  output logic            any_valid
);

  logic [IW:0] sum;
  logic        found;

  // Scan NREQ positions starting at rr_ptr; first hit wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        grant = sum[IW-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/uart_seq.sv
// UART bus-master sequencer: programs the UART, then round-robins TX requesters
// and drains received bytes into a one-entry valid/ready buffer.
// Optional UART_SEQ_STATS_EN adds tx_count / rx_count statistics outputs.
module uart_seq
  import uart_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CPB   = 216
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              init_done,
  output logic              u_cs,
  output logic              u_wen,
  output logic [3:0]        u_addr,
  output logic [WIDTH-1:0]  u_din,
  input  logic [WIDTH-1:0]  u_dout
`ifdef UART_SEQ_STATS_EN
  ,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count
`endif
);

  localparam int unsigned IW = idx_width(NREQ);

  state_t        state, state_nx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] arb_grant;
  logic [IW-1:0] grant_q;
  logic          any_valid;
  logic          prefer_tx;
  logic [7:0]    grant_byte;
  logic          grant_valid;
  logic          unused_dout;

  assign unused_dout = ^u_dout[WIDTH-1:8];

  uart_seq_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .any_valid (any_valid)
  );

  // Select the latched grant's current valid and byte
  always_comb begin
    grant_byte  = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q == IW'(k)) begin
        grant_byte  = req_data[8*k +: 8];
        grant_valid = req_valid[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= INIT_CPB;
    else       state <= state_nx;
  end

  // Next state and one-cycle bus access per access state
  always_comb begin
    state_nx  = state;
    u_cs      = 1'b0;
    u_wen     = 1'b0;
    u_addr    = '0;
    u_din     = '0;
    req_ready = '0;
    case (state)
      INIT_CPB: begin
        u_cs     = 1'b1;
        u_wen    = 1'b1;
        u_addr   = ADDR_CPB;
        u_din    = WIDTH'(CPB);
        state_nx = INIT_CTRL;
      end
      INIT_CTRL: begin
        u_cs     = 1'b1;
        u_wen    = 1'b1;
        u_addr   = ADDR_CTRL;
        u_din    = WIDTH'(CTRL_VAL);
        state_nx = IDLE;
      end
      IDLE: begin
        if (!rx_valid && any_valid) state_nx = prefer_tx ? TX_POLL : RX_POLL;
        else if (!rx_valid)         state_nx = RX_POLL;
        else if (any_valid)         state_nx = TX_POLL;
      end
      RX_POLL: begin
        u_cs     = 1'b1;
        u_addr   = ADDR_RSTAT;
        state_nx = u_dout[RXNE_BIT] ? RX_READ : IDLE;
      end
      RX_READ: begin
        u_cs     = 1'b1;
        u_addr   = ADDR_DR;
        state_nx = GAP;
      end
      TX_POLL: begin
        u_cs     = 1'b1;
        u_addr   = ADDR_TSTAT;
        state_nx = u_dout[TC_BIT] ? TX_WRITE : IDLE;
      end
      TX_WRITE: begin
        if (grant_valid) begin
          u_cs      = 1'b1;
          u_wen     = 1'b1;
          u_addr    = ADDR_DR;
          u_din     = WIDTH'(grant_byte);
          req_ready = NREQ'(1) << grant_q;
        end
        state_nx = GAP;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = INIT_CPB;
    endcase
    // Bus stays quiet while held in reset
    if (reset) begin
      u_cs      = 1'b0;
      u_wen     = 1'b0;
      u_addr    = '0;
      u_din     = '0;
      req_ready = '0;
    end
  end

  // Datapath: init flag, arbitration state and the RX output buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done <= 1'b0;
      prefer_tx <= 1'b0;
      rr_ptr    <= '0;
      grant_q   <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      if (state == INIT_CTRL) init_done <= 1'b1;
      if (state == RX_POLL) prefer_tx <= 1'b1;
      if (state == TX_POLL) begin
        prefer_tx <= 1'b0;
        if (u_dout[TC_BIT]) grant_q <= arb_grant;
      end
      if (state == TX_WRITE && grant_valid)
        rr_ptr <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
      if (state == RX_READ) begin
        rx_data  <= u_dout[7:0];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_SEQ_STATS_EN
  // Transfer statistics, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (state == TX_WRITE && grant_valid) tx_count <= tx_count + 16'd1;
      if (state == RX_READ)                 rx_count <= rx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_seq.sv
// Self-checking bench for uart_seq with a behavioural UART register model.
module tb_uart_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        init_done;
  logic        u_cs;
  logic        u_wen;
  logic [3:0]  u_addr;
  logic [31:0] u_din;
  logic [31:0] u_dout;
`ifdef UART_SEQ_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
`endif

  always #5 clk = ~clk;

  uart_seq #(.WIDTH(32), .NREQ(2), .CPB(216)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .init_done (init_done),
    .u_cs      (u_cs),
    .u_wen     (u_wen),
    .u_addr    (u_addr),
    .u_din     (u_din),
    .u_dout    (u_dout)
`ifdef UART_SEQ_STATS_EN
    ,
    .tx_count  (tx_count),
    .rx_count  (rx_count)
`endif
  );

  // UART register model
  logic       rstat, tstat;
  logic [7:0] dr_val;
  logic       tstat_rand, dr_rand;

  always_comb begin
    u_dout = '0;
    if (u_cs && !u_wen) begin
      case (u_addr)
        4'd0:    u_dout = {24'h0, dr_val};
        4'd2:    u_dout = {31'h0, rstat};
        4'd3:    u_dout = {31'h0, tstat};
        default: u_dout = '0;
      endcase
    end
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] wr_b[$];
  int         wr_i[$];
  logic [7:0] exp_b[$];
  int         exp_i[$];
  int         polls[$];
  logic [7:0] rx_got[$];
  logic [7:0] exp_rx[$];
  int m_ptr = 0;
  int n_rpoll, n_tpoll, n_drrd, n_dr_wr_tot, n_drrd_tot, n_other_wr;
  int n_idle_bad, n_multi, n_rdy_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req();
    req_valid[0]   = (q0.size() != 0);
    req_valid[1]   = (q1.size() != 0);
    req_data[7:0]  = (q0.size() != 0) ? q0[0] : 8'h00;
    req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // Round-robin expectation from the pending queues, two requesters
  task automatic model_expect();
    logic [7:0] a[$];
    logic [7:0] b[$];
    int c;
    a = q0;
    b = q1;
    while (a.size() + b.size() != 0) begin
      if (m_ptr == 0) c = (a.size() != 0) ? 0 : 1;
      else            c = (b.size() != 0) ? 1 : 0;
      if (c == 0) exp_b.push_back(a.pop_front());
      else        exp_b.push_back(b.pop_front());
      exp_i.push_back(c);
      m_ptr = 1 - c;
    end
  endtask

  // One clock: observe at negedge, update stimulus after posedge
  task automatic tick();
    logic pop0, pop1, dr_rd;
    @(negedge clk);
    dr_rd = 1'b0;
    if (u_cs) begin
      if (u_wen && u_addr == 4'd0) begin
        wr_b.push_back(u_din[7:0]);
        wr_i.push_back(req_ready == 2'b01 ? 0 : (req_ready == 2'b10 ? 1 : 9));
        n_dr_wr_tot++;
      end else if (u_wen) n_other_wr++;
      if (!u_wen && u_addr == 4'd2) begin n_rpoll++; polls.push_back(2); end
      if (!u_wen && u_addr == 4'd3) begin n_tpoll++; polls.push_back(3); end
      if (!u_wen && u_addr == 4'd0) begin
        n_drrd++; n_drrd_tot++; dr_rd = 1'b1;
        exp_rx.push_back(dr_val);
      end
    end else if (u_wen || u_addr != 4'd0 || u_din != 32'h0) n_idle_bad++;
    if (req_ready == 2'b11) n_multi++;
    if (req_ready != 2'b00 && !(u_cs && u_wen && u_addr == 4'd0)) n_rdy_bad++;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    pop0 = req_ready[0];
    pop1 = req_ready[1];
    @(posedge clk);
    #1;
    if (pop0 && q0.size() != 0) void'(q0.pop_front());
    if (pop1 && q1.size() != 0) void'(q1.pop_front());
    drive_req();
    if (tstat_rand) tstat = 1'($urandom_range(0, 1));
    if (dr_rand && dr_rd) dr_val = 8'($urandom_range(0, 255));
  endtask

  task automatic clear_wr();
    wr_b.delete(); wr_i.delete(); exp_b.delete(); exp_i.delete();
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, 32'(wr_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < wr_b.size() && i < exp_b.size(); i++) begin
      chk({tag, "_byte"}, 32'(wr_b[i]), 32'(exp_b[i]));
      chk({tag, "_ready_idx"}, 32'(wr_i[i]), 32'(exp_i[i]));
    end
  endtask

  initial begin
    int alt_bad;
    int n;
    logic found;
    reset = 1'b1; rx_ready = 1'b0; rstat = 1'b0; tstat = 1'b0; dr_val = 8'h00;
    tstat_rand = 1'b0; dr_rand = 1'b0;
    n_rpoll = 0; n_tpoll = 0; n_drrd = 0; n_dr_wr_tot = 0; n_drrd_tot = 0; n_other_wr = 0;
    n_idle_bad = 0; n_multi = 0; n_rdy_bad = 0;
    drive_req();

    // Reset state and the two init writes
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u_cs", 32'(u_cs), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_init_done", 32'(init_done), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("init1_bus", {u_cs, u_wen, 2'b0, u_addr}, 32'h0000_00C4);
    chk("init1_din", u_din, 32'd216);
    chk("init1_done", 32'(init_done), 32'h0);
    @(negedge clk);
    chk("init2_bus", {u_cs, u_wen, 2'b0, u_addr}, 32'h0000_00C1);
    chk("init2_din", u_din, 32'd3);
    @(negedge clk);
    chk("init3_done", 32'(init_done), 32'h1);
    chk("init3_u_cs", 32'(u_cs), 32'h0);

    // Nothing pending: only RSTAT polls
    repeat (30) tick();
    chk("idle_dr_writes", 32'(wr_b.size()), 32'h0);
    chk("idle_other_writes", 32'(n_other_wr), 32'h0);
    chk("idle_dr_reads", 32'(n_drrd), 32'h0);
    chk("idle_tstat_polls", 32'(n_tpoll), 32'h0);
    chk("idle_rstat_polled", 32'(n_rpoll > 0), 32'h1);

    // Two requesters, fixed bytes, TX always complete
    clear_wr();
    repeat (3) begin q0.push_back(8'h41); q1.push_back(8'h42); end
    drive_req();
    model_expect();
    tstat = 1'b1;
    for (int i = 0; i < 400 && wr_b.size() < exp_b.size(); i++) tick();
    compare_writes("rr_fixed");

    // Random loads with random transmit-complete status
    for (int r = 0; r < 3; r++) begin
      clear_wr();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) q0.push_back(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) q1.push_back(8'($urandom_range(0, 255)));
      drive_req();
      model_expect();
      tstat_rand = 1'b1;
      for (int i = 0; i < 3000 && wr_b.size() < exp_b.size(); i++) tick();
      tstat_rand = 1'b0;
      compare_writes("rr_rand");
    end

    // Transmitter busy for 10 polls, then exactly one write
    clear_wr();
    tstat = 1'b0;
    q0.push_back(8'h77);
    drive_req();
    model_expect();
    n_tpoll = 0;
    for (int i = 0; i < 500 && n_tpoll < 10; i++) tick();
    chk("busy_polls_seen", 32'(n_tpoll >= 10), 32'h1);
    chk("busy_no_write", 32'(wr_b.size()), 32'h0);
    tstat = 1'b1;
    repeat (30) tick();
    compare_writes("busy_then_ok");

    // RX with consumer stalled
    rstat = 1'b1; dr_val = 8'h5A; rx_ready = 1'b0;
    for (int i = 0; i < 100 && !rx_valid; i++) tick();
    chk("rx_valid_set", 32'(rx_valid), 32'h1);
    chk("rx_data", 32'(rx_data), 32'h5A);
    n_rpoll = 0;
    repeat (20) tick();
    chk("rx_stall_no_poll", 32'(n_rpoll), 32'h0);
    chk("rx_stall_hold", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    tick();
    chk("rx_valid_cleared", 32'(rx_valid), 32'h0);

    // Both paths pending: polls alternate; bytes still in order
    clear_wr();
    rx_got.delete(); exp_rx.delete(); polls.delete();
    dr_rand = 1'b1;
    dr_val = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'($urandom_range(0, 255)));
      q1.push_back(8'($urandom_range(0, 255)));
    end
    drive_req();
    model_expect();
    for (int i = 0; i < 600 && polls.size() < 16; i++) tick();
    chk("alt_poll_count", 32'(polls.size() >= 16), 32'h1);
    alt_bad = 0;
    for (int i = 1; i < polls.size(); i++) if (polls[i] == polls[i-1]) alt_bad++;
    chk("alt_polls", 32'(alt_bad), 32'h0);
    chk("alt_rx_seen", 32'(rx_got.size() > 0), 32'h1);
    for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++)
      chk("alt_rx_byte", 32'(rx_got[i]), 32'(exp_rx[i]));
    rstat = 1'b0;
    dr_rand = 1'b0;
    for (int i = 0; i < 2000 && wr_b.size() < exp_b.size(); i++) tick();
    compare_writes("alt_tx");

`ifdef UART_SEQ_STATS_EN
    chk("stats_tx", 32'(tx_count), 32'(n_dr_wr_tot));
    chk("stats_rx", 32'(rx_count), 32'(n_drrd_tot));
`endif

    // Reset in the middle of a TX write
    repeat (3) begin q0.push_back(8'($urandom_range(0, 255))); q1.push_back(8'h99); end
    drive_req();
    tstat = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) found = 1'b1;
    end
    chk("txw_reached", 32'(found), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'h0);
    chk("rst_mid_u_cs", 32'(u_cs), 32'h0);
    chk("rst_mid_init_done", 32'(init_done), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reinit1_bus", {u_cs, u_wen, 2'b0, u_addr}, 32'h0000_00C4);
    chk("reinit1_din", u_din, 32'd216);
`ifdef UART_SEQ_STATS_EN
    chk("stats_tx_rst", 32'(tx_count), 32'h0);
    chk("stats_rx_rst", 32'(rx_count), 32'h0);
`endif
    @(negedge clk);
    chk("reinit2_bus", {u_cs, u_wen, 2'b0, u_addr}, 32'h0000_00C1);
    chk("reinit2_din", u_din, 32'd3);
    @(negedge clk);
    chk("reinit_done", 32'(init_done), 32'h1);

    // Bus hygiene over the whole run
    chk("idle_bus_zero", 32'(n_idle_bad), 32'h0);
    chk("one_hot_ready", 32'(n_multi), 32'h0);
    chk("ready_with_write", 32'(n_rdy_bad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
